// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the proc_pipe processor.
//   - Opcode encodings and instruction field bit positions.
//   - Control portion of a pipeline stage register. The data fields depend on DATA_W,
//     so each stage adds them in proc_pipe.
//   - Opcode classification helpers.
package proc_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 28;
  localparam int unsigned ISEL_BIT = 27;
  localparam int unsigned RD_HI    = 26;
  localparam int unsigned RD_LO    = 22;
  localparam int unsigned RA_HI    = 21;
  localparam int unsigned RA_LO    = 17;
  localparam int unsigned RB_HI    = 16;
  localparam int unsigned RB_LO    = 12;

  // Width of a register field in the instruction word (before truncation to RA_W).
  localparam int unsigned REG_FIELD_W = 5;

  typedef struct packed {
    logic                   valid;
    logic [3:0]             op;
    logic [REG_FIELD_W-1:0] rd;
    logic                   illegal;
  } stage_ctrl_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_LI;
  endfunction

  // Opcodes 1..8 produce a register result. NOP and the illegal opcodes do not.
  function automatic logic op_writes(input logic [3:0] op);
    return (op != OP_NOP) && !op_is_illegal(op);
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: register file with 2 combinational read ports and 1 write port.
//   clk_i, rst_i        clock and asynchronous active-high reset (clears every register)
//   raddr_a_i/rdata_a_o read port A
//   raddr_b_i/rdata_b_o read port B
//   we_i, waddr_i, wdata_i  write port; a write to R0 is dropped
// R0 always reads as zero.
module proc_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a_i,
  output logic [DATA_W-1:0]           rdata_a_o,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b_i,
  output logic [DATA_W-1:0]           rdata_b_o,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]           wdata_i
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Entry 0 is cleared by reset and never written, so it stays a constant zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/proc_pipe.sv
// proc_pipe: 3-stage in-order pipeline (D: decode/register read at accept, E: ALU,
// W: writeback and result port) with full E->D and W->D forwarding.
//   clk, reset       clock and asynchronous active-high reset
//   ir, ir_valid     instruction input channel; ir_ready = pipe accepts ir this cycle
//   a_out, b_out     operands of the instruction in E
//   w_out, w_addr    result and destination register of the instruction in W
//   w_valid, w_ready result output channel; backpressure stalls the whole pipe
//   illegal          instruction in W had an undefined opcode (qualified by w_valid)
//   retired_cnt      retired instruction count (PROC_PERF_CNT_EN only, else 0)
//   stall_cnt        stall cycle count (PROC_PERF_CNT_EN only, else 0)
// Define PROC_PERF_CNT_EN to build the performance counters.
module proc_pipe
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IMM_W    = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 ir,
  input  logic                        ir_valid,
  output logic                        ir_ready,
  output logic [DATA_W-1:0]           a_out,
  output logic [DATA_W-1:0]           b_out,
  output logic [DATA_W-1:0]           w_out,
  output logic [$clog2(NUM_REGS)-1:0] w_addr,
  output logic                        w_valid,
  input  logic                        w_ready,
  output logic                        illegal,
  output logic [31:0]                 retired_cnt,
  output logic [31:0]                 stall_cnt
);

  localparam int unsigned RA_W = $clog2(NUM_REGS);
  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef struct packed {
    stage_ctrl_t       ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } de_t;

  typedef struct packed {
    stage_ctrl_t       ctrl;
    logic [DATA_W-1:0] res;
  } ew_t;

  de_t de_q, de_d;
  ew_t ew_q, ew_d;

  logic stall, accept, w_fire, rf_we;

  // Decode of the instruction presented at D
  logic [3:0]               d_op;
  logic                     d_isel;
  logic [RA_W-1:0]          d_rd, d_ra, d_rb;
  logic signed [IMM_W-1:0]  d_imm_raw;
  logic [DATA_W-1:0]        d_imm, d_a, d_b;
  logic [DATA_W-1:0]        rf_a, rf_b;

  logic [RA_W-1:0]   e_rd, w_rd;
  logic              e_fwd_ok, w_fwd_ok;
  logic [DATA_W-1:0] e_res;

  assign d_op      = ir[OP_HI:OP_LO];
  assign d_isel    = ir[ISEL_BIT];
  assign d_rd      = RA_W'(ir[RD_HI:RD_LO]);
  assign d_ra      = RA_W'(ir[RA_HI:RA_LO]);
  assign d_rb      = RA_W'(ir[RB_HI:RB_LO]);
  assign d_imm_raw = ir[IMM_W-1:0];
  assign d_imm     = DATA_W'(d_imm_raw);

  assign stall    = ew_q.ctrl.valid & ~w_ready;
  assign ir_ready = ~stall;
  assign accept   = ir_valid & ir_ready;
  assign w_fire   = ew_q.ctrl.valid & w_ready;
  assign rf_we    = w_fire & op_writes(ew_q.ctrl.op);

  proc_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (reset),
    .raddr_a_i (d_ra),
    .rdata_a_o (rf_a),
    .raddr_b_i (d_rb),
    .rdata_b_o (rf_b),
    .we_i      (rf_we),
    .waddr_i   (w_rd),
    .wdata_i   (ew_q.res)
  );

  // Forwarding sources: only valid, result-producing instructions targeting a non-zero register.
  assign e_rd     = de_q.ctrl.rd[RA_W-1:0];
  assign w_rd     = ew_q.ctrl.rd[RA_W-1:0];
  assign e_fwd_ok = de_q.ctrl.valid && op_writes(de_q.ctrl.op) && (e_rd != '0);
  assign w_fwd_ok = ew_q.ctrl.valid && op_writes(ew_q.ctrl.op) && (w_rd != '0);

  // The E check comes last so the younger result wins over W and the regfile.
  always_comb begin
    d_a = rf_a;
    if (w_fwd_ok && (w_rd == d_ra)) d_a = ew_q.res;
    if (e_fwd_ok && (e_rd == d_ra)) d_a = e_res;

    d_b = rf_b;
    if (w_fwd_ok && (w_rd == d_rb)) d_b = ew_q.res;
    if (e_fwd_ok && (e_rd == d_rb)) d_b = e_res;
    // LI takes its value from the immediate regardless of isel.
    if (d_isel || (d_op == OP_LI)) d_b = d_imm;
  end

  // ALU. NOP, illegal opcodes and bubbles all produce zero.
  always_comb begin
    e_res = '0;
    case (de_q.ctrl.op)
      OP_ADD:  e_res = de_q.a + de_q.b;
      OP_SUB:  e_res = de_q.a - de_q.b;
      OP_AND:  e_res = de_q.a & de_q.b;
      OP_OR:   e_res = de_q.a | de_q.b;
      OP_XOR:  e_res = de_q.a ^ de_q.b;
      OP_SLL:  e_res = de_q.a << de_q.b[SH_W-1:0];
      OP_SRL:  e_res = de_q.a >> de_q.b[SH_W-1:0];
      OP_LI:   e_res = de_q.b;
      default: e_res = '0;
    endcase
  end

  // Stage advance. A stall freezes both stage registers. Otherwise D/E takes the accepted
  // instruction or an all-zero bubble.
  always_comb begin
    de_d = de_q;
    ew_d = ew_q;
    if (!stall) begin
      ew_d.ctrl = de_q.ctrl;
      ew_d.res  = e_res;
      de_d      = '0;
      if (accept) begin
        de_d.ctrl.valid   = 1'b1;
        de_d.ctrl.op      = d_op;
        de_d.ctrl.rd      = REG_FIELD_W'(d_rd);
        de_d.ctrl.illegal = op_is_illegal(d_op);
        de_d.a            = d_a;
        de_d.b            = d_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q <= '0;
      ew_q <= '0;
    end else begin
      de_q <= de_d;
      ew_q <= ew_d;
    end
  end

  assign a_out   = de_q.a;
  assign b_out   = de_q.b;
  assign w_out   = ew_q.res;
  assign w_addr  = w_rd;
  assign w_valid = ew_q.ctrl.valid;
  assign illegal = ew_q.ctrl.illegal;

`ifdef PROC_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    retired_d   = retired_q;
    stall_cnt_d = stall_cnt_q;
    if (w_fire) retired_d = retired_q + 32'd1;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      retired_q   <= retired_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_cnt_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_proc_pipe.sv
// tb_proc_pipe: directed, table-driven bench for proc_pipe at default parameters.
// Each table row is driven for one cycle; ir_ready is compared before the edge and the
// stage outputs after it. A hand-written sequence covers reset asserted during a stall.
module tb_proc_pipe;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned IMM_W    = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] a_out, b_out, w_out;
  logic [4:0]  w_addr;
  logic        w_valid;
  logic        w_ready;
  logic        illegal;
  logic [31:0] retired_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_pipe #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IMM_W    (IMM_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .a_out       (a_out),
    .b_out       (b_out),
    .w_out       (w_out),
    .w_addr      (w_addr),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .illegal     (illegal),
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic [31:0] ir;
    logic        ir_valid;
    logic        w_ready;
    logic        exp_ir_ready;
    logic        exp_w_valid;
    logic [31:0] exp_w_out;
    logic [4:0]  exp_w_addr;
    logic        exp_illegal;
    logic        chk_ab;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic isel,
                                      input logic [4:0] rd, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [11:0] imm);
    return {op, isel, rd, ra, rb, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] ir_v, input logic iv, input logic wr,
                              input logic irr, input logic wv, input logic [31:0] wo,
                              input logic [4:0] wa, input logic ill, input logic cab,
                              input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.ir = ir_v; v.ir_valid = iv; v.w_ready = wr;
    v.exp_ir_ready = irr; v.exp_w_valid = wv; v.exp_w_out = wo; v.exp_w_addr = wa;
    v.exp_illegal = ill; v.chk_ab = cab; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic chk_zero_state(input string tag);
    chk({tag, " w_valid"}, 32'(w_valid), 32'd0);
    chk({tag, " w_out"}, w_out, 32'd0);
    chk({tag, " w_addr"}, 32'(w_addr), 32'd0);
    chk({tag, " a_out"}, a_out, 32'd0);
    chk({tag, " b_out"}, b_out, 32'd0);
    chk({tag, " illegal"}, 32'(illegal), 32'd0);
    chk({tag, " retired_cnt"}, retired_cnt, 32'd0);
    chk({tag, " stall_cnt"}, stall_cnt, 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] exp_ret, exp_stl;

    //            ir                          iv wr  irr wv w_out         wa ill ab a   b
    // Independent ops
    vecs.push_back(mk(enc(8, 1, 1, 0, 0, 12'd5),   1, 1, 1, 0, 0,            0, 0, 1, 0,  5));
    vecs.push_back(mk(enc(8, 1, 2, 0, 0, 12'hFFD), 1, 1, 1, 1, 5,            1, 0, 1, 0,  32'hFFFF_FFFD));
    vecs.push_back(mk(enc(1, 0, 3, 1, 2, 12'd0),   1, 1, 1, 1, 32'hFFFF_FFFD, 2, 0, 1, 5, 32'hFFFF_FFFD));
    // Dependency chain: LI R1,7; ADD R2,R1,R1; SUB R3,R2,R1
    vecs.push_back(mk(enc(8, 1, 1, 0, 0, 12'd7),   1, 1, 1, 1, 2,            3, 0, 1, 0,  7));
    vecs.push_back(mk(enc(1, 0, 2, 1, 1, 12'd0),   1, 1, 1, 1, 7,            1, 0, 1, 7,  7));
    vecs.push_back(mk(enc(2, 0, 3, 2, 1, 12'd0),   1, 1, 1, 1, 14,           2, 0, 1, 14, 7));
    // LI R0,9; ADD R4,R0,R0
    vecs.push_back(mk(enc(8, 1, 0, 0, 0, 12'd9),   1, 1, 1, 1, 7,            3, 0, 1, 0,  9));
    vecs.push_back(mk(enc(1, 0, 4, 0, 0, 12'd0),   1, 1, 1, 1, 9,            0, 0, 1, 0,  0));
    // Fill the pipe, then 3 cycles of backpressure with ADD R7,R5,R6 waiting
    vecs.push_back(mk(enc(8, 1, 5, 0, 0, 12'd11),  1, 1, 1, 1, 0,            4, 0, 1, 0,  11));
    vecs.push_back(mk(enc(1, 0, 6, 1, 1, 12'd0),   1, 1, 1, 1, 11,           5, 0, 1, 7,  7));
    vecs.push_back(mk(enc(1, 0, 7, 5, 6, 12'd0),   1, 0, 0, 1, 11,           5, 0, 1, 7,  7));
    vecs.push_back(mk(enc(1, 0, 7, 5, 6, 12'd0),   1, 0, 0, 1, 11,           5, 0, 1, 7,  7));
    vecs.push_back(mk(enc(1, 0, 7, 5, 6, 12'd0),   1, 0, 0, 1, 11,           5, 0, 1, 7,  7));
    vecs.push_back(mk(enc(1, 0, 7, 5, 6, 12'd0),   1, 1, 1, 1, 14,           6, 0, 1, 11, 14));
    // Illegal op 12 targeting R1, then SLL R5,R1,#33, then ADD R8,R1,R0 to read R1 back
    vecs.push_back(mk(enc(12, 0, 1, 1, 1, 12'd0),  1, 1, 1, 1, 25,           7, 0, 0, 0,  0));
    vecs.push_back(mk(enc(6, 1, 5, 1, 0, 12'd33),  1, 1, 1, 1, 0,            1, 1, 1, 7,  33));
    vecs.push_back(mk(enc(1, 0, 8, 1, 0, 12'd0),   1, 1, 1, 1, 14,           5, 0, 1, 7,  0));
    vecs.push_back(mk(32'd0,                       0, 1, 1, 1, 7,            8, 0, 1, 0,  0));
    vecs.push_back(mk(32'd0,                       0, 1, 1, 0, 0,            0, 0, 0, 0,  0));

    ir       = '0;
    ir_valid = 1'b0;
    w_ready  = 1'b1;
    reset    = 1'b1;
    #2;
    chk_zero_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("ir_ready after reset", 32'(ir_ready), 32'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      ir       = vecs[i].ir;
      ir_valid = vecs[i].ir_valid;
      w_ready  = vecs[i].w_ready;
      #1 chk($sformatf("v%0d ir_ready", i), 32'(ir_ready), 32'(vecs[i].exp_ir_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d w_valid", i), 32'(w_valid), 32'(vecs[i].exp_w_valid));
      if (vecs[i].exp_w_valid) begin
        chk($sformatf("v%0d w_out", i), w_out, vecs[i].exp_w_out);
        chk($sformatf("v%0d w_addr", i), 32'(w_addr), 32'(vecs[i].exp_w_addr));
        chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].exp_illegal));
      end
      if (vecs[i].chk_ab) begin
        chk($sformatf("v%0d a_out", i), a_out, vecs[i].exp_a);
        chk($sformatf("v%0d b_out", i), b_out, vecs[i].exp_b);
      end
    end

`ifdef PROC_PERF_CNT_EN
    exp_ret = 32'd14;
    exp_stl = 32'd3;
`else
    exp_ret = 32'd0;
    exp_stl = 32'd0;
`endif
    chk("retired_cnt", retired_cnt, exp_ret);
    chk("stall_cnt", stall_cnt, exp_stl);

    // Reset during a stall with LI R1,3 in W and LI R2,4 in E
    @(negedge clk);
    ir       = enc(8, 1, 1, 0, 0, 12'd3);
    ir_valid = 1'b1;
    w_ready  = 1'b1;
    @(negedge clk);
    ir = enc(8, 1, 2, 0, 0, 12'd4);
    @(negedge clk);
    ir_valid = 1'b0;
    w_ready  = 1'b0;
    #1 chk("inflight ir_ready", 32'(ir_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("inflight w_valid", 32'(w_valid), 32'd1);
    chk("inflight w_out", w_out, 32'd3);
    chk("inflight b_out", b_out, 32'd4);
    #2 reset = 1'b1;
    #1 chk_zero_state("stall reset");
    @(negedge clk);
    reset   = 1'b0;
    w_ready = 1'b1;
    #1 chk("post-reset ir_ready", 32'(ir_ready), 32'd1);
    ir       = enc(1, 0, 1, 1, 1, 12'd0);
    ir_valid = 1'b1;
    @(posedge clk);
    #1 chk("post-reset add in E w_valid", 32'(w_valid), 32'd0);
    @(negedge clk);
    ir_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset add w_valid", 32'(w_valid), 32'd1);
    chk("post-reset add w_out", w_out, 32'd0);
    chk("post-reset add w_addr", 32'(w_addr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_pipe.md
Name: proc_pipe

Overview:
- Parametrised successor to the single-cycle processor top.
- 3-stage in-order pipeline: D (decode and register read, at accept), E (ALU), W (writeback and result port).
- Instructions enter over a valid/ready channel. Results leave over a valid/ready channel; backpressure on that channel stalls the whole pipe.
- Full E→D and W→D forwarding, so there are no data-hazard stalls. Exposes a_out/b_out/w_out for observation, as the previous top did.

Parameters:
- DATA_W, 32, datapath width (≥8).
- NUM_REGS, 32, register count (power of 2, 2..32); address width RA_W = $clog2(NUM_REGS).
- IMM_W, 12, immediate field width, sign-extended to DATA_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ir  in  32  instruction
- ir_valid  in  1  ir holds a valid instruction
- ir_ready  out  1  pipe accepts ir this cycle
- a_out  out  DATA_W  operand A of instruction in E
- b_out  out  DATA_W  operand B (or immediate) of instruction in E
- w_out  out  DATA_W  result of instruction in W
- w_addr  out  RA_W  destination register of instruction in W
- w_valid  out  1  W holds a retiring instruction
- w_ready  in  1  consumer accepts the result
- illegal  out  1  instruction in W had an undefined opcode (qualified by w_valid)
- retired_cnt  out  32  retired instruction count (optional feature)
- stall_cnt  out  32  stall cycle count (optional feature)

Behaviour:
- Fields:
  - op = ir[31:28]; isel = ir[27]; rd = ir[26:22]; ra = ir[21:17]; rb = ir[16:12]; imm = ir[IMM_W-1:0].
  - Register fields are truncated to RA_W bits.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 LI (result = sext(imm)).
  - 9–15 are illegal.
- Operand B is sext(imm) when isel=1, else R[rb].
- Arithmetic wraps mod 2^DATA_W.
- SLL/SRL are logical shifts by B[$clog2(DATA_W)-1:0].
- R0 reads 0; writes to R0 are dropped.
- Handshakes:
  - stall = w_valid & ~w_ready.
  - ir_ready = ~stall (combinational).
  - Accept when ir_valid & ir_ready.
- Stall: while stall is high, D/E and E/W registers and a_out/b_out/w_out/w_addr hold.
- Advance (no stall): E/W ← E; D/E ← accepted instruction. If nothing is accepted, D/E gets a bubble (valid=0).
- Latency:
  - Instruction accepted at edge N appears in E (a_out/b_out) after edge N.
  - w_valid is high after edge N+1, i.e. exactly 2 cycles when unstalled.
- Regfile:
  - Written at the edge where w_valid & w_ready.
  - Written only when op ∈ {1..8}, rd≠0 and not illegal.
- Forwarding priority for each D read: E-stage result (if valid, writing, same rd≠0) > W-stage result (same conditions) > regfile.
- Regfile write and D read of the same register in the same cycle: forwarding already supplies the value, so read-during-write ordering is irrelevant.
- NOP and illegal instructions still retire (w_valid=1). Their w_out=0. illegal=1 only for opcodes 9–15.
- Reset (asynchronous, any time, including during a stall):
  - All stage valids, a_out, b_out, w_out, w_addr, illegal and counters go to 0.
  - Registers R1..R(NUM_REGS-1) go to 0.
  - ir_ready=1 the cycle after reset deasserts.

Optional Feature:
- PROC_PERF_CNT_EN defined:
  - retired_cnt increments on each w_valid & w_ready.
  - stall_cnt increments each cycle stall=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 0 and no counter flops exist.

Decomposition:
- proc_pkg: opcode localparams, field bit positions, stage-register struct (valid, op, rd, a, b, illegal).
- Sub-module proc_regfile (params DATA_W, NUM_REGS):
  - 2 combinational read ports, 1 write port.
  - R0 hardwired to zero; asynchronous reset.
- ALU, forwarding and handshake logic stay in proc_pipe.

Test Plan:
- Independent ops, w_ready=1: LI R1,5; LI R2,-3; ADD R3,R1,R2. Required: w_out = 5, 0xFFFFFFFD, 2 on consecutive cycles, each 2 cycles after accept; ir_ready stays 1.
- Back-to-back dependency chain: LI R1,7; ADD R2,R1,R1; SUB R3,R2,R1. Required: b_out=7 on the ADD via E-forward; w_out=14 then 7; no bubbles.
- LI R0,9 then ADD R4,R0,R0. Required: second result 0; w_addr=0 on the first.
- Hold w_ready=0 for 3 cycles while w_valid=1. Required: ir_ready=0, w_out/a_out stable; stall_cnt=3 when the macro is enabled; pipe resumes with no loss or duplication.
- op=12. Required: w_valid with illegal=1, w_out=0, no register changed; SLL R5,R1,imm 33 with DATA_W=32 yields R1<<1.
- Assert reset during a stall with 2 instructions in flight. Required: w_valid=0, outputs 0 immediately; subsequent ADD R1,R1,R1 yields 0.
